// File: rtl/clock_pkg.sv
// Shared types, digit limits and BCD increment helpers
// for the HH:MM:SS clock timebase.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam int CLK_HZ_DEF = 50_000_000;

  localparam logic [3:0] LIM_TENS_MS = 4'd5;
  localparam logic [3:0] LIM_ONES    = 4'd9;
  localparam logic [3:0] LIM_H10     = 4'd2;
  localparam logic [3:0] LIM_H1_AT_2 = 4'd3;

  // Returns {carry, next} for a 00..59 BCD pair.
  function automatic logic [8:0] inc_bcd60(
    input logic [7:0] v
  );
    if (v[3:0] == LIM_ONES) begin
      if (v[7:4] == LIM_TENS_MS)
        return {1'b1, 8'h00};
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_bcd24(
    input logic [7:0] v
  );
    if (v[7:4] == LIM_H10 && v[3:0] == LIM_H1_AT_2)
      return 8'h00;
    if (v[3:0] == LIM_ONES)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_timebase_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability
// counter and a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_50Mhz,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counting only while the input disagrees with the accepted
  // level means any bounce back resets the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST)
        level_d = sync2_q;
      else
        cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_timebase.sv
// 24h BCD clock with run/set-hour/set-minute modes.
// Define CLOCK_BLINK_EN to blink the digits being set.
module clock_timebase
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk_50Mhz,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] time_bcd,
  output logic        tick_1hz,
  output logic [1:0]  mode,
  output logic [5:0]  blank_mask
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);

  logic          mode_press, inc_press;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  mode_e         mode_q, mode_d;
  logic [23:0]   time_q, time_d;
  logic [8:0]    sec_inc, min_inc;
  logic [7:0]    hr_inc;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .btn_raw   (btn_mode),
    .press     (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .btn_raw   (btn_inc),
    .press     (inc_press)
  );

  always_comb begin
    sec_inc = inc_bcd60(time_q[7:0]);
    min_inc = inc_bcd60(time_q[15:8]);
    hr_inc  = inc_bcd24(time_q[23:16]);
    presc_d = (presc_q == P_LAST) ? '0 : presc_q + PW'(1);
    mode_d  = mode_q;
    time_d  = time_q;
    if (mode_q == MODE_RUN && tick_q) begin
      time_d[7:0] = sec_inc[7:0];
      if (sec_inc[8]) begin
        time_d[15:8] = min_inc[7:0];
        if (min_inc[8])
          time_d[23:16] = hr_inc;
      end
    end
    // Mode press wins; a coincident inc press is dropped.
    if (mode_press) begin
      unique case (mode_q)
        MODE_RUN:    mode_d = MODE_SET_HR;
        MODE_SET_HR: mode_d = MODE_SET_MIN;
        MODE_SET_MIN: begin
          mode_d      = MODE_RUN;
          time_d[7:0] = 8'h00;
          presc_d     = '0;
        end
        default:     mode_d = MODE_RUN;
      endcase
    end else if (inc_press) begin
      unique case (mode_q)
        MODE_SET_HR:  time_d[23:16] = hr_inc;
        MODE_SET_MIN: time_d[15:8]  = min_inc[7:0];
        default:      ;
      endcase
    end
    tick_d = (presc_d == P_LAST);
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_RUN;
      time_q  <= 24'h000000;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      time_q  <= time_d;
    end
  end

`ifdef CLOCK_BLINK_EN
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);

  logic [5:0] blank_q, blank_d;

  // Derived from next-state so the mask lines up with presc_q.
  always_comb begin
    blank_d = 6'b000000;
    if (presc_d >= P_HALF) begin
      unique case (mode_d)
        MODE_SET_HR:  blank_d = 6'b110000;
        MODE_SET_MIN: blank_d = 6'b001100;
        default:      blank_d = 6'b000000;
      endcase
    end
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst)
      blank_q <= 6'b000000;
    else
      blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = 6'b000000;
`endif

  assign time_bcd = time_q;
  assign tick_1hz = tick_q;
  assign mode     = mode_q;

endmodule
